// File: rtl/pixel_gen_pkg.sv
// ---------------------------------------------------------------------------
// pixel_gen_pkg
// Shared definitions for the pixel pattern generator:
//   - gen_state_e     : frame sequencing FSM states
//   - P_ODD_*         : encodings of the p_odd last-beat qualifier
//   - LANE_CNT_W      : width of a valid-lane count (0..4 lanes)
//   - ceil_div        : integer ceiling division (beats per line)
//   - max3            : largest of three integers (counter sizing)
//   - bits_for_count  : bits needed for a counter running 0..n-1
//   - p_odd_code      : maps a short-beat lane count to its p_odd code
// ---------------------------------------------------------------------------
package pixel_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FSYNC  = 3'd1,
        ST_HBLANK = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VBLANK = 3'd4
    } gen_state_e;

    localparam logic [1:0] P_ODD_FULL  = 2'b00;
    localparam logic [1:0] P_ODD_ONE   = 2'b01;
    localparam logic [1:0] P_ODD_TWO   = 2'b10;
    localparam logic [1:0] P_ODD_THREE = 2'b11;

    localparam int LANE_CNT_W = 3;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // A counter that only ever holds 0..n-1 still needs at least one bit.
    function automatic int bits_for_count(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [1:0] p_odd_code(input int shortLanes);
        case (shortLanes)
            1:       return P_ODD_ONE;
            2:       return P_ODD_TWO;
            3:       return P_ODD_THREE;
            default: return P_ODD_FULL;
        endcase
    endfunction

endpackage

// File: rtl/pixel_lane_pack.sv
// ---------------------------------------------------------------------------
// pixel_lane_pack
// Purely combinational lane packer. Lane k of the beat carries pix_i+k when
// k is below the valid-lane count, and zero otherwise. Also returns the pixel
// counter value that follows this beat (pix_i advanced by the valid lanes).
// Ports:
//   pix_i       in   PIXEL_WIDTH               current pixel counter P
//   lanes_i     in   LANE_CNT_W                number of valid lanes (0 = none)
//   data_o      out  PIXEL_WIDTH*NUM_PIXELS    packed lanes, lane 0 in LSBs
//   pix_next_o  out  PIXEL_WIDTH               P after this beat
// ---------------------------------------------------------------------------
module pixel_lane_pack
    import pixel_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int NUM_PIXELS  = 1
) (
    input  logic [PIXEL_WIDTH-1:0]            pix_i,
    input  logic [LANE_CNT_W-1:0]             lanes_i,
    output logic [PIXEL_WIDTH*NUM_PIXELS-1:0] data_o,
    output logic [PIXEL_WIDTH-1:0]            pix_next_o
);

    // Lanes beyond the valid count are forced to zero so a short last beat
    // never shows stale or speculative pixel values. All arithmetic wraps
    // naturally at PIXEL_WIDTH bits.
    always_comb begin
        data_o     = '0;
        pix_next_o = pix_i + PIXEL_WIDTH'(lanes_i);
        for (int k = 0; k < NUM_PIXELS; k++) begin
            if (LANE_CNT_W'(k) < lanes_i) begin
                data_o[k*PIXEL_WIDTH +: PIXEL_WIDTH] = pix_i + PIXEL_WIDTH'(k);
            end
        end
    end

endmodule

// File: rtl/pixel_pattern_gen.sv
// ---------------------------------------------------------------------------
// pixel_pattern_gen
// Parallel pixel-bus source producing frames of incrementing-count pixels
// with programmable active and blanking geometry.
// Ports:
//   clk_pixel_i    in   1    pixel clock
//   reset_pixel_i  in   1    asynchronous active-high reset
//   enable_i       in   1    generate frames while high (sampled in IDLE and
//                            at the end of VBLANK)
//   frame_valid_o  out  1    FSYNC through last ACTIVE beat
//   line_valid_o   out  1    ACTIVE beats
//   de_o           out  1    same as line_valid_o
//   vsync_o        out  1    one-cycle pulse in FSYNC
//   hsync_o        out  1    first HSYNC_W cycles of each HBLANK
//   pixel_data_o   out  PIXEL_WIDTH*NUM_PIXELS  packed pixels, lane 0 in LSBs
//   p_odd_o        out  2    valid-lane count on a short last beat, else 0
//   frame_done_o   out  1    pulse on the first VBLANK cycle
//   frame_cnt_o    out  16   completed frame count, wraps
//   busy_o         out  1    high whenever not IDLE
// ---------------------------------------------------------------------------
module pixel_pattern_gen
    import pixel_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int NUM_PIXELS  = 1,
    parameter int H_ACTIVE    = 16,
    parameter int H_BLANK     = 4,
    parameter int HSYNC_W     = 1,
    parameter int V_ACTIVE    = 4,
    parameter int V_BLANK     = 8
) (
    input  logic                              clk_pixel_i,
    input  logic                              reset_pixel_i,
    input  logic                              enable_i,
    output logic                              frame_valid_o,
    output logic                              line_valid_o,
    output logic                              de_o,
    output logic                              vsync_o,
    output logic                              hsync_o,
    output logic [PIXEL_WIDTH*NUM_PIXELS-1:0] pixel_data_o,
    output logic [1:0]                        p_odd_o,
    output logic                              frame_done_o,
    output logic [15:0]                       frame_cnt_o,
    output logic                              busy_o
);

    localparam int BEATS      = ceil_div(H_ACTIVE, NUM_PIXELS);
    localparam int LAST_LANES = H_ACTIVE - (BEATS - 1) * NUM_PIXELS;
    localparam int PHASE_MAX  = max3(H_BLANK, BEATS, V_BLANK);
    localparam int PH_W       = bits_for_count(PHASE_MAX);
    localparam int LINE_W     = bits_for_count(V_ACTIVE);

    localparam logic [PH_W-1:0]       HB_LAST    = PH_W'(H_BLANK - 1);
    localparam logic [PH_W-1:0]       HS_LAST    = PH_W'(HSYNC_W - 1);
    localparam logic [PH_W-1:0]       BEAT_LAST  = PH_W'(BEATS - 1);
    localparam logic [PH_W-1:0]       VB_LAST    = PH_W'(V_BLANK - 1);
    localparam logic [LINE_W-1:0]     LINE_LAST  = LINE_W'(V_ACTIVE - 1);
    localparam logic [LANE_CNT_W-1:0] FULL_LANES = LANE_CNT_W'(NUM_PIXELS);
    localparam logic [LANE_CNT_W-1:0] TAIL_LANES = LANE_CNT_W'(LAST_LANES);
    localparam logic [1:0]            P_ODD_LAST = p_odd_code(H_ACTIVE % NUM_PIXELS);

    gen_state_e                       state_q, state_d;
    logic [PH_W-1:0]                  phaseCnt_q, phaseCnt_d;
    logic [LINE_W-1:0]                lineCnt_q, lineCnt_d;
    logic [PIXEL_WIDTH-1:0]           pixCnt_q, pixCnt_d;
    logic [15:0]                      frameCnt_q, frameCnt_d;
    logic [LANE_CNT_W-1:0]            lanes_d;
    logic [PIXEL_WIDTH*NUM_PIXELS-1:0] packData;
    logic [PIXEL_WIDTH-1:0]           packNext;

    logic                             frameValid_q;
    logic                             lineValid_q;
    logic                             vsync_q;
    logic                             hsync_q;
    logic [PIXEL_WIDTH*NUM_PIXELS-1:0] data_q;
    logic [1:0]                       pOdd_q;
    logic                             frameDone_q;
    logic                             busy_q;

    // Next-state logic. phaseCnt counts cycles inside HBLANK, ACTIVE and
    // VBLANK and restarts from zero on every state change; lineCnt counts
    // lines of the current frame. The frame counter advances on the edge
    // that enters VBLANK so it moves together with frame_done.
    always_comb begin
        state_d    = state_q;
        phaseCnt_d = phaseCnt_q;
        lineCnt_d  = lineCnt_q;
        frameCnt_d = frameCnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_FSYNC;
                end
            end
            ST_FSYNC: begin
                state_d    = ST_HBLANK;
                phaseCnt_d = '0;
                lineCnt_d  = '0;
            end
            ST_HBLANK: begin
                if (phaseCnt_q == HB_LAST) begin
                    state_d    = ST_ACTIVE;
                    phaseCnt_d = '0;
                end else begin
                    phaseCnt_d = phaseCnt_q + PH_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (phaseCnt_q == BEAT_LAST) begin
                    phaseCnt_d = '0;
                    if (lineCnt_q < LINE_LAST) begin
                        state_d   = ST_HBLANK;
                        lineCnt_d = lineCnt_q + LINE_W'(1);
                    end else begin
                        state_d    = ST_VBLANK;
                        frameCnt_d = frameCnt_q + 16'd1;
                    end
                end else begin
                    phaseCnt_d = phaseCnt_q + PH_W'(1);
                end
            end
            ST_VBLANK: begin
                if (phaseCnt_q == VB_LAST) begin
                    phaseCnt_d = '0;
                    state_d    = enable_i ? ST_FSYNC : ST_IDLE;
                end else begin
                    phaseCnt_d = phaseCnt_q + PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Lane count of the beat about to be issued. Only the final beat of a
    // line can be short; outside ACTIVE no lanes are valid, which makes the
    // packer emit zero data and leaves the pixel counter untouched.
    always_comb begin
        lanes_d = '0;
        if (state_d == ST_ACTIVE) begin
            lanes_d = (phaseCnt_d == BEAT_LAST) ? TAIL_LANES : FULL_LANES;
        end
    end

    pixel_lane_pack #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .NUM_PIXELS  (NUM_PIXELS)
    ) u_lanePack (
        .pix_i      (pixCnt_q),
        .lanes_i    (lanes_d),
        .data_o     (packData),
        .pix_next_o (packNext)
    );

    // pixCnt_q always holds the first pixel value of the next beat to go
    // out. Entering FSYNC restarts the pattern at zero for the new frame.
    always_comb begin
        pixCnt_d = pixCnt_q;
        if (state_d == ST_FSYNC) begin
            pixCnt_d = '0;
        end else if (state_d == ST_ACTIVE) begin
            pixCnt_d = packNext;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_pixel_i or posedge reset_pixel_i) begin
        if (reset_pixel_i) begin
            state_q    <= ST_IDLE;
            phaseCnt_q <= '0;
            lineCnt_q  <= '0;
            pixCnt_q   <= '0;
            frameCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            phaseCnt_q <= phaseCnt_d;
            lineCnt_q  <= lineCnt_d;
            pixCnt_q   <= pixCnt_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    // Output registers, decoded from the next state so every output lines up
    // with the state it describes while still coming straight from a flop.
    // The async reset clears them at once, which is what a mid-frame reset
    // needs downstream.
    always_ff @(posedge clk_pixel_i or posedge reset_pixel_i) begin
        if (reset_pixel_i) begin
            frameValid_q <= 1'b0;
            lineValid_q  <= 1'b0;
            vsync_q      <= 1'b0;
            hsync_q      <= 1'b0;
            data_q       <= '0;
            pOdd_q       <= P_ODD_FULL;
            frameDone_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frameValid_q <= (state_d == ST_FSYNC) || (state_d == ST_HBLANK) ||
                            (state_d == ST_ACTIVE);
            lineValid_q  <= (state_d == ST_ACTIVE);
            vsync_q      <= (state_d == ST_FSYNC);
            hsync_q      <= (state_d == ST_HBLANK) && (phaseCnt_d <= HS_LAST);
            data_q       <= packData;
            pOdd_q       <= ((state_d == ST_ACTIVE) && (phaseCnt_d == BEAT_LAST)) ?
                            P_ODD_LAST : P_ODD_FULL;
            frameDone_q  <= (state_d == ST_VBLANK) && (state_q != ST_VBLANK);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign frame_valid_o = frameValid_q;
    assign line_valid_o  = lineValid_q;
    assign de_o          = lineValid_q;
    assign vsync_o       = vsync_q;
    assign hsync_o       = hsync_q;
    assign pixel_data_o  = data_q;
    assign p_odd_o       = pOdd_q;
    assign frame_done_o  = frameDone_q;
    assign frame_cnt_o   = frameCnt_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_pixel_pattern_gen
// Drives four differently configured generators and compares every output
// cycle by cycle against a frame-geometry model computed from the frame
// timing rules (cycle offset -> line, beat, pixel values).
// ---------------------------------------------------------------------------
module tb_pixel_pattern_gen;

    localparam int CPW  [4] = '{8, 8, 8, 4};
    localparam int CNP  [4] = '{1, 2, 4, 4};
    localparam int CHA  [4] = '{4, 5, 6, 20};
    localparam int CHB  [4] = '{2, 3, 2, 2};
    localparam int CHSW [4] = '{1, 2, 1, 2};
    localparam int CVA  [4] = '{2, 2, 3, 2};
    localparam int CVB  [4] = '{3, 2, 2, 1};

    logic clk = 1'b0;
    logic [3:0] rst = 4'h0;
    logic [3:0] en  = 4'h0;

    logic [3:0]       fv, lv, de, vs, hs, fd, busy;
    logic [3:0][1:0]  po;
    logic [3:0][15:0] fc;
    logic [7:0]       d0;
    logic [15:0]      d1;
    logic [31:0]      d2;
    logic [15:0]      d3;

    int nTests = 0;
    int nFails = 0;
    int expCnt [4] = '{0, 0, 0, 0};
    logic [31:0] beatLog [$];
    logic [1:0]  poLog [$];
    int vsyncAt [$];
    int hsyncCycles;
    int doneCount;
    int cyc;

    always #5 clk = ~clk;

    pixel_pattern_gen #(.PIXEL_WIDTH(CPW[0]), .NUM_PIXELS(CNP[0]), .H_ACTIVE(CHA[0]),
        .H_BLANK(CHB[0]), .HSYNC_W(CHSW[0]), .V_ACTIVE(CVA[0]), .V_BLANK(CVB[0])) u_dut0 (
        .clk_pixel_i(clk), .reset_pixel_i(rst[0]), .enable_i(en[0]),
        .frame_valid_o(fv[0]), .line_valid_o(lv[0]), .de_o(de[0]), .vsync_o(vs[0]),
        .hsync_o(hs[0]), .pixel_data_o(d0), .p_odd_o(po[0]), .frame_done_o(fd[0]),
        .frame_cnt_o(fc[0]), .busy_o(busy[0]));

    pixel_pattern_gen #(.PIXEL_WIDTH(CPW[1]), .NUM_PIXELS(CNP[1]), .H_ACTIVE(CHA[1]),
        .H_BLANK(CHB[1]), .HSYNC_W(CHSW[1]), .V_ACTIVE(CVA[1]), .V_BLANK(CVB[1])) u_dut1 (
        .clk_pixel_i(clk), .reset_pixel_i(rst[1]), .enable_i(en[1]),
        .frame_valid_o(fv[1]), .line_valid_o(lv[1]), .de_o(de[1]), .vsync_o(vs[1]),
        .hsync_o(hs[1]), .pixel_data_o(d1), .p_odd_o(po[1]), .frame_done_o(fd[1]),
        .frame_cnt_o(fc[1]), .busy_o(busy[1]));

    pixel_pattern_gen #(.PIXEL_WIDTH(CPW[2]), .NUM_PIXELS(CNP[2]), .H_ACTIVE(CHA[2]),
        .H_BLANK(CHB[2]), .HSYNC_W(CHSW[2]), .V_ACTIVE(CVA[2]), .V_BLANK(CVB[2])) u_dut2 (
        .clk_pixel_i(clk), .reset_pixel_i(rst[2]), .enable_i(en[2]),
        .frame_valid_o(fv[2]), .line_valid_o(lv[2]), .de_o(de[2]), .vsync_o(vs[2]),
        .hsync_o(hs[2]), .pixel_data_o(d2), .p_odd_o(po[2]), .frame_done_o(fd[2]),
        .frame_cnt_o(fc[2]), .busy_o(busy[2]));

    pixel_pattern_gen #(.PIXEL_WIDTH(CPW[3]), .NUM_PIXELS(CNP[3]), .H_ACTIVE(CHA[3]),
        .H_BLANK(CHB[3]), .HSYNC_W(CHSW[3]), .V_ACTIVE(CVA[3]), .V_BLANK(CVB[3])) u_dut3 (
        .clk_pixel_i(clk), .reset_pixel_i(rst[3]), .enable_i(en[3]),
        .frame_valid_o(fv[3]), .line_valid_o(lv[3]), .de_o(de[3]), .vsync_o(vs[3]),
        .hsync_o(hs[3]), .pixel_data_o(d3), .p_odd_o(po[3]), .frame_done_o(fd[3]),
        .frame_cnt_o(fc[3]), .busy_o(busy[3]));

    // Observed outputs of one generator packed as
    // {pad7, fcnt16, fv, lv, de, vs, hs, fd, busy, p_odd2, data32}.
    function automatic logic [63:0] obs_vec(input int d);
        logic [31:0] dat;
        case (d)
            0:       dat = 32'(d0);
            1:       dat = 32'(d1);
            2:       dat = d2;
            default: dat = 32'(d3);
        endcase
        return {7'd0, fc[d], fv[d], lv[d], de[d], vs[d], hs[d], fd[d], busy[d], po[d], dat};
    endfunction

    function automatic int frame_period(input int d);
        int beats;
        beats = (CHA[d] + CNP[d] - 1) / CNP[d];
        return 1 + CVA[d] * (CHB[d] + beats) + CVB[d];
    endfunction

    // Expected outputs t cycles after the FSYNC cycle of a frame that starts
    // with 'base' completed frames.
    function automatic logic [63:0] model_vec(input int d, input int t, input int base);
        int beats, lp, vbStart, line, c, b, first, lanes, pix;
        logic fvE, lvE, vsE, hsE, fdE;
        logic [1:0] poE;
        logic [31:0] datE;
        logic [15:0] fcE;
        beats   = (CHA[d] + CNP[d] - 1) / CNP[d];
        lp      = CHB[d] + beats;
        vbStart = 1 + CVA[d] * lp;
        fvE  = (t < vbStart);
        vsE  = (t == 0);
        fdE  = (t == vbStart);
        fcE  = 16'((t >= vbStart) ? base + 1 : base);
        lvE  = 1'b0;
        hsE  = 1'b0;
        poE  = 2'd0;
        datE = 32'd0;
        if (t >= 1 && t < vbStart) begin
            line = (t - 1) / lp;
            c    = (t - 1) % lp;
            if (c < CHB[d]) begin
                hsE = (c < CHSW[d]);
            end else begin
                b     = c - CHB[d];
                first = b * CNP[d];
                lanes = CHA[d] - first;
                if (lanes > CNP[d]) lanes = CNP[d];
                lvE = 1'b1;
                if (lanes < CNP[d]) poE = 2'(lanes);
                for (int k = 0; k < lanes; k++) begin
                    pix  = (line * CHA[d] + first + k) % (1 << CPW[d]);
                    datE = datE | (32'(pix) << (k * CPW[d]));
                end
            end
        end
        return {7'd0, fcE, fvE, lvE, lvE, vsE, hsE, fdE, 1'b1, poE, datE};
    endfunction

    // Scenario engine: optional idle gap, then nFrames frames with enable
    // either held or randomly toggled between sample points. In the last
    // frame enable is forced low from cycle dropAt on, so the generator must
    // return to IDLE. Must be entered at a falling clock edge.
    task automatic walk_frames(input int d, input int gap, input int nFrames,
                               input bit toggle, input int dropAt);
        int per;
        logic [63:0] expV, actV;
        per = frame_period(d);
        beatLog.delete();
        poLog.delete();
        vsyncAt.delete();
        hsyncCycles = 0;
        doneCount   = 0;
        cyc         = 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            cyc++;
            expV = {7'd0, 16'(expCnt[d]), 41'd0};
            actV = obs_vec(d);
            nTests++;
            if (actV !== expV) begin
                nFails++;
                $display("[TB] FAIL idle_gap dut%0d cyc %0d: got %h want %h", d, cyc, actV, expV);
            end
        end
        en[d] = 1'b1;
        for (int f = 0; f < nFrames; f++) begin
            for (int t = 0; t < per; t++) begin
                @(negedge clk);
                cyc++;
                expV = model_vec(d, t, expCnt[d]);
                actV = obs_vec(d);
                nTests++;
                if (actV !== expV) begin
                    nFails++;
                    $display("[TB] FAIL frame_cycle dut%0d frame %0d t %0d: got %h want %h",
                             d, f, t, actV, expV);
                end
                if (expV[39]) begin
                    beatLog.push_back(actV[31:0]);
                    poLog.push_back(actV[33:32]);
                end
                if (vs[d]) vsyncAt.push_back(cyc);
                if (hs[d]) hsyncCycles++;
                if (fd[d]) doneCount++;
                if (f < nFrames - 1) begin
                    en[d] = (t == per - 1) ? 1'b1 : (toggle ? 1'($urandom_range(1, 0)) : 1'b1);
                end else begin
                    en[d] = (t >= dropAt) ? 1'b0 : (toggle ? 1'($urandom_range(1, 0)) : 1'b1);
                end
            end
            expCnt[d] = (expCnt[d] + 1) & 16'hFFFF;
        end
        @(negedge clk);
        cyc++;
        expV = {7'd0, 16'(expCnt[d]), 41'd0};
        actV = obs_vec(d);
        nTests++;
        if (actV !== expV) begin
            nFails++;
            $display("[TB] FAIL back_to_idle dut%0d: got %h want %h", d, actV, expV);
        end
    endtask

    task automatic test_reset();
        logic [63:0] actV;
        rst = 4'h0;
        en  = 4'h0;
        #1;
        rst = 4'hF;
        #1;
        for (int d = 0; d < 4; d++) begin
            actV = obs_vec(d);
            nTests++;
            if (actV !== 64'd0) begin
                nFails++;
                $display("[TB] FAIL reset_async dut%0d: got %h want 0", d, actV);
            end
        end
        repeat (3) @(negedge clk);
        rst = 4'h0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            actV = obs_vec(d);
            nTests++;
            if (actV !== 64'd0) begin
                nFails++;
                $display("[TB] FAIL idle_after_reset dut%0d: got %h want 0", d, actV);
            end
        end
    endtask

    task automatic test_back_to_back();
        walk_frames(0, int'($urandom_range(3, 0)), 2, 1'b1, frame_period(0) - 1);
        nTests++;
        if (vsyncAt.size() != 2) begin
            nFails++;
            $display("[TB] FAIL vsync_count: got %0d want 2", vsyncAt.size());
        end else begin
            nTests++;
            if (vsyncAt[1] - vsyncAt[0] != 16) begin
                nFails++;
                $display("[TB] FAIL vsync_spacing: got %0d want 16", vsyncAt[1] - vsyncAt[0]);
            end
        end
        nTests++;
        if (hsyncCycles != 4) begin
            nFails++;
            $display("[TB] FAIL hsync_count: got %0d want 4", hsyncCycles);
        end
        nTests++;
        if (doneCount != 2) begin
            nFails++;
            $display("[TB] FAIL done_count_b2b: got %0d want 2", doneCount);
        end
        nTests++;
        if (beatLog.size() != 16) begin
            nFails++;
            $display("[TB] FAIL beat_count_np1: got %0d want 16", beatLog.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                nTests++;
                if (beatLog[i] !== 32'(i % 8)) begin
                    nFails++;
                    $display("[TB] FAIL np1_data beat %0d: got %h want %h", i, beatLog[i], i % 8);
                end
            end
        end
    endtask

    task automatic test_np2_lanes();
        logic [31:0] wantData [6];
        logic [1:0]  wantPo   [6];
        int pixels;
        wantData = '{32'h0100, 32'h0302, 32'h0004, 32'h0605, 32'h0807, 32'h0009};
        wantPo   = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
        walk_frames(1, int'($urandom_range(3, 0)), 1, 1'b0, frame_period(1) - 1);
        nTests++;
        if (beatLog.size() != 6) begin
            nFails++;
            $display("[TB] FAIL beat_count_np2: got %0d want 6", beatLog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                nTests++;
                if (beatLog[i] !== wantData[i] || poLog[i] !== wantPo[i]) begin
                    nFails++;
                    $display("[TB] FAIL np2_beat %0d: got %h/%0d want %h/%0d",
                             i, beatLog[i], poLog[i], wantData[i], wantPo[i]);
                end
            end
            for (int l = 0; l < 2; l++) begin
                pixels = 0;
                for (int b = 0; b < 3; b++) begin
                    pixels += (poLog[l*3+b] == 2'd0) ? 2 : int'(poLog[l*3+b]);
                end
                nTests++;
                if (pixels != 5) begin
                    nFails++;
                    $display("[TB] FAIL np2_pixels_per_line %0d: got %0d want 5", l, pixels);
                end
            end
        end
    endtask

    task automatic test_np4_lanes();
        walk_frames(2, int'($urandom_range(3, 0)), 1, 1'b1, frame_period(2) - 1);
        nTests++;
        if (beatLog.size() != 6) begin
            nFails++;
            $display("[TB] FAIL beat_count_np4: got %0d want 6", beatLog.size());
        end else begin
            nTests++;
            if (beatLog[0] !== 32'h03020100 || poLog[0] !== 2'd0) begin
                nFails++;
                $display("[TB] FAIL np4_first_beat: got %h/%0d want 03020100/0", beatLog[0], poLog[0]);
            end
            nTests++;
            if (beatLog[1] !== 32'h00000504 || poLog[1] !== 2'd2) begin
                nFails++;
                $display("[TB] FAIL np4_short_beat: got %h/%0d want 00000504/2", beatLog[1], poLog[1]);
            end
            nTests++;
            if (beatLog[2] !== 32'h09080706) begin
                nFails++;
                $display("[TB] FAIL np4_next_line: got %h want 09080706", beatLog[2]);
            end
        end
    endtask

    task automatic test_pw4_wrap();
        int nonZeroPo;
        walk_frames(3, int'($urandom_range(3, 0)), 1, 1'b0, frame_period(3) - 1);
        nonZeroPo = 0;
        foreach (poLog[i]) if (poLog[i] != 2'd0) nonZeroPo++;
        nTests++;
        if (beatLog.size() != 10 || nonZeroPo != 0) begin
            nFails++;
            $display("[TB] FAIL pw4_podd: beats %0d nonzero p_odd %0d want 10/0",
                     beatLog.size(), nonZeroPo);
        end else begin
            nTests++;
            if (beatLog[3] !== 32'hFEDC || beatLog[4] !== 32'h3210) begin
                nFails++;
                $display("[TB] FAIL pw4_wrap: got %h %h want fedc 3210", beatLog[3], beatLog[4]);
            end
        end
    endtask

    task automatic test_enable_drop();
        int prevCnt;
        prevCnt = expCnt[0];
        walk_frames(0, 1, 1, 1'b0, int'($urandom_range(12, 7)));
        nTests++;
        if (doneCount != 1) begin
            nFails++;
            $display("[TB] FAIL drop_done_count: got %0d want 1", doneCount);
        end
        nTests++;
        if (fc[0] !== 16'(prevCnt + 1)) begin
            nFails++;
            $display("[TB] FAIL drop_frame_cnt: got %0d want %0d", fc[0], prevCnt + 1);
        end
        repeat (3) begin
            @(negedge clk);
            nTests++;
            if (busy[0] !== 1'b0 || vs[0] !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL drop_stays_idle: got busy %b vsync %b want 0 0", busy[0], vs[0]);
            end
        end
    endtask

    task automatic test_reset_mid_active();
        int tgt;
        logic [63:0] actV;
        tgt = 1 + int'($urandom_range(2, 0)) * 4 + 2 + int'($urandom_range(1, 0));
        en[2] = 1'b1;
        for (int t = 0; t <= tgt; t++) @(negedge clk);
        nTests++;
        if (lv[2] !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL mid_active_reached: got lv %b want 1", lv[2]);
        end
        rst[2] = 1'b1;
        #1;
        actV = obs_vec(2);
        nTests++;
        if (actV !== 64'd0) begin
            nFails++;
            $display("[TB] FAIL reset_mid_active: got %h want 0", actV);
        end
        @(negedge clk);
        rst[2] = 1'b0;
        expCnt[2] = 0;
        walk_frames(2, 0, 1, 1'b0, frame_period(2) - 1);
        nTests++;
        if (beatLog.size() == 0 || beatLog[0] !== 32'h03020100) begin
            nFails++;
            $display("[TB] FAIL restart_first_beat: got %h want 03020100",
                     (beatLog.size() == 0) ? 32'hFFFFFFFF : beatLog[0]);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_np2_lanes();
        test_np4_lanes();
        test_pw4_wrap();
        test_enable_drop();
        test_reset_mid_active();
        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
